// File: rtl/board_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : board_mem_arbiter
// Purpose  : Shares the single-port, synchronous-read snake board RAM between
//            the VGA fetch path (strict priority) and the game engine, which
//            uses the idle cycles. On reset, or on a clear request, the whole
//            board is swept to INIT_VAL before arbitration resumes.
// Ports    : clk, reset                      - clock, async active-high reset
//            vga_re/vga_raddr                - VGA read request / address
//            vga_rdata/vga_rvalid            - VGA read return (1-cycle latency)
//            g_req/g_we/g_addr/g_wdata       - game access request
//            g_gnt                           - game access accepted this cycle
//            g_rdata/g_rvalid                - game read return (1-cycle latency)
//            g_starved                       - game request waited STARVE_LIMIT
//            clr_req                         - restart a full board clear
//            init_done                       - high once the clear has finished
//            mem_en/mem_we/mem_addr/mem_wdata/mem_rdata - board RAM port
// Revision : 1.0 - initial release
// ============================================================================
module board_mem_arbiter #(
  parameter int            AW           = 10,
  parameter int            DW           = 8,
  parameter logic [DW-1:0] INIT_VAL     = '0,
  parameter int            STARVE_LIMIT = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          vga_re,
  input  logic [AW-1:0] vga_raddr,
  output logic [DW-1:0] vga_rdata,
  output logic          vga_rvalid,
  input  logic          g_req,
  input  logic          g_we,
  input  logic [AW-1:0] g_addr,
  input  logic [DW-1:0] g_wdata,
  output logic          g_gnt,
  output logic [DW-1:0] g_rdata,
  output logic          g_rvalid,
  output logic          g_starved,
  input  logic          clr_req,
  output logic          init_done,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int            WCW        = $clog2(STARVE_LIMIT + 1);
  localparam logic [WCW-1:0] STARVE_MAX = WCW'(STARVE_LIMIT);

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // TAG_VGA_INIT marks a VGA read accepted during the clear: the RAM was busy
  // writing, so the return carries INIT_VAL instead of mem_rdata.
  typedef enum logic [1:0] {
    TAG_NONE     = 2'd0,
    TAG_VGA      = 2'd1,
    TAG_GAME     = 2'd2,
    TAG_VGA_INIT = 2'd3
  } tag_t;

  state_t         state;
  tag_t           tag;
  logic [AW-1:0]  clr_cnt;
  logic [WCW-1:0] wait_cnt;
  logic           run;

  assign run   = (state == S_RUN);
  assign g_gnt = run && !vga_re && g_req;

  // RAM port steering; enables are forced low while reset is held so no
  // write can slip out before the clear sweep formally begins.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!run) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = clr_cnt;
      mem_wdata = INIT_VAL;
    end else if (vga_re) begin
      mem_en   = 1'b1;
      mem_addr = vga_raddr;
    end else if (g_req) begin
      mem_en    = 1'b1;
      mem_we    = g_we;
      mem_addr  = g_addr;
      mem_wdata = g_wdata;
    end
    if (reset) begin
      mem_en = 1'b0;
      mem_we = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_INIT;
      clr_cnt  <= '0;
      tag      <= TAG_NONE;
      wait_cnt <= '0;
    end else begin
      // Return tag for the access issued this cycle.
      if (run) begin
        if (vga_re)             tag <= TAG_VGA;
        else if (g_req && !g_we) tag <= TAG_GAME;
        else                    tag <= TAG_NONE;
      end else begin
        tag <= vga_re ? TAG_VGA_INIT : TAG_NONE;
      end

      // Starvation counter runs in both states; saturates at the limit.
      if (g_req && !g_gnt) begin
        if (wait_cnt != STARVE_MAX) wait_cnt <= wait_cnt + WCW'(1);
      end else begin
        wait_cnt <= '0;
      end

      case (state)
        S_INIT: begin
          if (clr_req) begin
            clr_cnt <= '0;
          end else begin
            // Wraps to zero on the last address, ready for the next clear.
            clr_cnt <= clr_cnt + AW'(1);
            if (&clr_cnt) state <= S_RUN;
          end
        end
        S_RUN: begin
          if (clr_req) begin
            state   <= S_INIT;
            clr_cnt <= '0;
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

  assign vga_rvalid = (tag == TAG_VGA) || (tag == TAG_VGA_INIT);
  assign vga_rdata  = (tag == TAG_VGA)      ? mem_rdata :
                      (tag == TAG_VGA_INIT) ? INIT_VAL  : '0;
  assign g_rvalid   = (tag == TAG_GAME);
  assign g_rdata    = g_rvalid ? mem_rdata : '0;
  assign g_starved  = (wait_cnt == STARVE_MAX);
  assign init_done  = run;

endmodule
`default_nettype wire

// File: tb/tb_board_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_board_mem_arbiter
// Purpose  : Self-checking bench for board_mem_arbiter (AW=6, INIT_VAL=A5,
//            STARVE_LIMIT=4) with a behavioural synchronous-read board RAM.
//            Read returns are checked by a scoreboard monitor; grant, clear
//            and starvation behaviour by directed checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_board_mem_arbiter;

  localparam int         AW = 6;
  localparam int         DW = 8;
  localparam logic [7:0] IV = 8'hA5;
  localparam int         NCELL = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          vga_re;
  logic [AW-1:0] vga_raddr;
  logic [DW-1:0] vga_rdata;
  logic          vga_rvalid;
  logic          g_req;
  logic          g_we;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_wdata;
  logic          g_gnt;
  logic [DW-1:0] g_rdata;
  logic          g_rvalid;
  logic          g_starved;
  logic          clr_req;
  logic          init_done;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  board_mem_arbiter #(
    .AW(AW), .DW(DW), .INIT_VAL(IV), .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .reset(reset),
    .vga_re(vga_re), .vga_raddr(vga_raddr), .vga_rdata(vga_rdata), .vga_rvalid(vga_rvalid),
    .g_req(g_req), .g_we(g_we), .g_addr(g_addr), .g_wdata(g_wdata), .g_gnt(g_gnt),
    .g_rdata(g_rdata), .g_rvalid(g_rvalid), .g_starved(g_starved),
    .clr_req(clr_req), .init_done(init_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Board RAM: single port, synchronous read.
  logic [DW-1:0] ram [0:NCELL-1];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cyc;
    logic [7:0] d;
  } ret_t;
  ret_t vq[$];
  ret_t gq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Pushes are made during the issuing cycle; the return is due next cycle.
  task automatic push_v(input logic [7:0] d);
    ret_t e;
    e.cyc = cyc + 1;
    e.d   = d;
    vq.push_back(e);
  endtask

  task automatic push_g(input logic [7:0] d);
    ret_t e;
    e.cyc = cyc + 1;
    e.d   = d;
    gq.push_back(e);
  endtask

  // Scoreboard monitor: a due entry must see rvalid with matching data;
  // any rvalid with nothing due is a spurious return.
  always @(negedge clk) begin
    if (vq.size() > 0 && vq[0].cyc <= cyc) begin
      checks++;
      if (!vga_rvalid || vga_rdata !== vq[0].d || vq[0].cyc != cyc) begin
        errors++;
        $display("FAIL vga_return: got valid=%0b data=%0h expected valid=1 data=%0h (cycle %0d)",
                 vga_rvalid, vga_rdata, vq[0].d, cyc);
      end
      void'(vq.pop_front());
    end else if (vga_rvalid) begin
      checks++;
      errors++;
      $display("FAIL vga_spurious: got valid=1 data=%0h expected valid=0 (cycle %0d)", vga_rdata, cyc);
    end
    if (gq.size() > 0 && gq[0].cyc <= cyc) begin
      checks++;
      if (!g_rvalid || g_rdata !== gq[0].d || gq[0].cyc != cyc) begin
        errors++;
        $display("FAIL game_return: got valid=%0b data=%0h expected valid=1 data=%0h (cycle %0d)",
                 g_rvalid, g_rdata, gq[0].d, cyc);
      end
      void'(gq.pop_front());
    end else if (g_rvalid) begin
      checks++;
      errors++;
      $display("FAIL game_spurious: got valid=1 data=%0h expected valid=0 (cycle %0d)", g_rdata, cyc);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_vals(input string name);
    chk({name, "_flags"}, {vga_rvalid, g_rvalid, g_gnt, g_starved, init_done, mem_en, mem_we}, 0);
    chk({name, "_vga_rdata"}, vga_rdata, 0);
    chk({name, "_g_rdata"}, g_rdata, 0);
  endtask

  // Full clear sweep starting in INIT cycle 0; optional VGA read at cycle vga_at.
  task automatic clear_sweep(input string name, input int vga_at);
    logic [16:0] e;
    for (int i = 0; i < NCELL; i++) begin
      vga_re    = (i == vga_at);
      vga_raddr = 6'h11;
      if (i == vga_at) push_v(IV);
      @(negedge clk);
      e = {1'b0, 1'b1, 1'b1, 6'(i), IV};
      chk({name, "_write"}, {init_done, mem_en, mem_we, mem_addr, mem_wdata}, e);
      next_cycle();
    end
    vga_re = 1'b0;
    @(negedge clk);
    chk({name, "_init_done"}, init_done, 1);
    next_cycle();
  endtask

  task automatic game_op(input logic we, input logic [5:0] addr, input logic [7:0] wd,
                         input logic [7:0] exp_rd, output int waited);
    g_req   = 1'b1;
    g_we    = we;
    g_addr  = addr;
    g_wdata = wd;
    waited  = 0;
    @(negedge clk);
    while (!g_gnt && waited < 100) begin
      next_cycle();
      @(negedge clk);
      waited++;
    end
    chk("game_grant", g_gnt, 1);
    if (g_gnt && !we) push_g(exp_rd);
    next_cycle();
    g_req = 1'b0;
    g_we  = 1'b0;
  endtask

  task automatic vga_read(input logic [5:0] addr, input logic [7:0] exp_d);
    vga_re    = 1'b1;
    vga_raddr = addr;
    push_v(exp_d);
    next_cycle();
    vga_re = 1'b0;
  endtask

  // VGA and game read of 0x2A contend for n cycles, then VGA drops.
  task automatic contend(input string name, input int n, input bit chk_starve);
    for (int i = 1; i <= n; i++) begin
      vga_re    = 1'b1;
      vga_raddr = 6'h2A;
      g_req     = 1'b1;
      g_we      = 1'b0;
      g_addr    = 6'h2A;
      push_v(8'h05);
      @(negedge clk);
      chk({name, "_gnt_blocked"}, g_gnt, 0);
      if (chk_starve) chk({name, "_starved"}, g_starved, (i >= 5) ? 1 : 0);
      next_cycle();
    end
    vga_re = 1'b0;
    @(negedge clk);
    chk({name, "_gnt_free"}, g_gnt, 1);
    if (chk_starve) chk({name, "_starved_at_grant"}, g_starved, 1);
    push_g(8'h05);
    next_cycle();
    g_req = 1'b0;
    @(negedge clk);
    chk({name, "_starved_clear"}, g_starved, 0);
    next_cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    reset = 1'b1; vga_re = 1'b0; vga_raddr = '0; g_req = 1'b0; g_we = 1'b0;
    g_addr = '0; g_wdata = '0; clr_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    reset_vals("reset");
    next_cycle();
    reset = 1'b0;

    // Power-up clear with a VGA read in INIT cycle 3.
    clear_sweep("clear0", 3);

    // Game write then VGA read-back.
    game_op(1'b1, 6'h2A, 8'h05, 8'h00, w);
    chk("grant_latency", w, 0);
    vga_read(6'h2A, 8'h05);
    next_cycle();

    // Contention: VGA wins for 3 cycles, then game read granted.
    contend("contend3", 3, 1'b0);

    // Starvation flag with STARVE_LIMIT=4.
    contend("starve", 6, 1'b1);

    // Back-to-back game reads, then write and read of another cell.
    game_op(1'b1, 6'h03, 8'h3C, 8'h00, w);
    game_op(1'b0, 6'h03, 8'h00, 8'h3C, w);
    game_op(1'b0, 6'h2A, 8'h00, 8'h05, w);

    // Clear request alongside a granted game read.
    clr_req = 1'b1;
    game_op(1'b0, 6'h2A, 8'h00, 8'h05, w);
    clr_req = 1'b0;
    clear_sweep("clear1", -1);
    vga_read(6'h2A, IV);
    game_op(1'b0, 6'h2A, 8'h00, IV, w);

    // Reset asserted mid-clear at clr_cnt=7 with a VGA return pending.
    clr_req = 1'b1;
    @(negedge clk);
    chk("clr_run_state", init_done, 1);
    next_cycle();
    clr_req = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("clear2_addr", mem_addr, i);
      next_cycle();
    end
    vga_re = 1'b1;
    @(negedge clk);
    chk("clear2_addr7", mem_addr, 7);
    next_cycle();
    reset  = 1'b1;
    vga_re = 1'b0;
    @(negedge clk);
    reset_vals("midreset");
    next_cycle();
    reset = 1'b0;
    clear_sweep("clear3", -1);
    game_op(1'b0, 6'h03, 8'h00, IV, w);
    repeat (2) next_cycle();

    chk("vga_queue_empty", vq.size(), 0);
    chk("game_queue_empty", gq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/board_mem_arbiter.md
# board_mem_arbiter

Sequences and shares the single-port, synchronous-read snake board RAM between the VGA fetch path (`vga_controller` `re`/`raddr`) and the game engine. The VGA path has strict priority, and game reads and writes fill the idle cycles. On reset, and on request, it clears the whole board to a fixed value before normal arbitration resumes. It sits between `vga_top`, the game logic and the board RAM macro.

## Interface
Parameters:
- `AW`, 10: board RAM address width; the board has 2^AW cells.
- `DW`, 8: cell width; `vga_top` consumes bits [2:0] as state.
- `INIT_VAL`, 8'h00: value written to every cell during clear.
- `STARVE_LIMIT`, 64: consecutive ungranted game-request cycles before `g_starved` asserts.

Ports:
- `clk`, in, 1: system clock; all state changes on the rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `vga_re`, in, 1: VGA read request, single-cycle strobe.
- `vga_raddr`, in, AW: VGA read address.
- `vga_rdata`, out, DW: VGA read data.
- `vga_rvalid`, out, 1: `vga_rdata` is valid this cycle.
- `g_req`, in, 1: game access request.
- `g_we`, in, 1: 1 selects write, 0 selects read.
- `g_addr`, in, AW: game access address.
- `g_wdata`, in, DW: game write data.
- `g_gnt`, out, 1: game access accepted this cycle.
- `g_rdata`, out, DW: game read data.
- `g_rvalid`, out, 1: `g_rdata` is valid this cycle.
- `g_starved`, out, 1: the game request has waited `STARVE_LIMIT` cycles.
- `clr_req`, in, 1: board clear request, single-cycle pulse.
- `init_done`, out, 1: high in RUN, low in INIT.
- `mem_en`, out, 1: RAM enable.
- `mem_we`, out, 1: RAM write enable.
- `mem_addr`, out, AW: RAM address.
- `mem_wdata`, out, DW: RAM write data.
- `mem_rdata`, in, DW: RAM read data, valid one cycle after an enabled read.

## Operation
FSM states are INIT and RUN. Reset forces INIT with `clr_cnt`=0.

INIT:
- `mem_en`=1, `mem_we`=1, `mem_addr`=`clr_cnt`, `mem_wdata`=`INIT_VAL`; `clr_cnt` increments each cycle.
- After the cycle that writes address 2^AW-1, the state goes to RUN and `clr_cnt` returns to 0.
- `g_gnt`=0, so game requests wait.
- A `vga_re` in INIT does not touch the RAM. `vga_rvalid` still pulses one cycle later, with `vga_rdata`=`INIT_VAL`.
- `clr_req` in INIT restarts the clear: `clr_cnt` is set to 0.

RUN, priority per cycle:
1. If `vga_re`=1: RAM read of `vga_raddr`, with `g_gnt`=0.
2. Else if `g_req`=1: `g_gnt`=1 combinationally in the same cycle. The RAM performs a read or write at `g_addr` per `g_we`, with `mem_wdata`=`g_wdata`.
3. Else: `mem_en`=0.

Game handshake:
- The game holds `g_req`, `g_we`, `g_addr` and `g_wdata` stable until it samples `g_gnt`=1.
- One access is performed per granted cycle. If `g_req` stays high after a grant, it is a new access.

Read return:
- A registered return tag (NONE, VGA, GAME) routes `mem_rdata` on the following cycle.
- VGA tag: `vga_rvalid`=1, `vga_rdata`=`mem_rdata`.
- GAME tag: `g_rvalid`=1, `g_rdata`=`mem_rdata`.
- Writes produce no valid pulse.

Clear from RUN:
- On `clr_req`, the current cycle's arbitration completes normally, and the next cycle enters INIT.
- The read return pending from the last RUN cycle is still delivered during the first INIT cycle.

Starvation counter:
- `wait_cnt` increments in cycles where `g_req`=1 and `g_gnt`=0, and saturates at `STARVE_LIMIT`.
- It clears to 0 on a grant, or when `g_req`=0.
- `g_starved` = (`wait_cnt`==`STARVE_LIMIT`).
- The counter also counts during INIT.

Priority is not altered by starvation. `g_starved` is a status flag only.

## Timing
- Reset values: `vga_rvalid`=0, `g_rvalid`=0, `g_gnt`=0, `g_starved`=0, `init_done`=0, `vga_rdata`=0, `g_rdata`=0, return tag NONE.
- While `reset`=1, `mem_en` and `mem_we` are gated to 0. INIT writes start on the first edge after `reset` deasserts.
- Full clear takes exactly 2^AW cycles, so `init_done` rises 2^AW cycles after reset release or after `clr_req`.
- Read latency is 1 cycle from `vga_re` or a granted game read to its rvalid, for both paths.
- `g_gnt` has zero-cycle latency from `g_req` when `vga_re`=0 in RUN.
- Back-to-back reads on both paths return in issue order, one per cycle, with no bubbles.
- If `reset` asserts mid-clear or mid-read, the pending return is dropped, no rvalid is produced, and the block enters INIT.

## Test plan
- Reset release with AW=4: 16 consecutive INIT writes to addresses 0..15 of `INIT_VAL`, and `init_done` rises on cycle 16. A `vga_re` issued in cycle 3 returns `INIT_VAL` with `vga_rvalid` in cycle 4.
- RUN: game write of 0x05 to address 0x2A, then `vga_re` with `vga_raddr`=0x2A. Required: `vga_rvalid` one cycle later with `vga_rdata`=0x05, and no `g_rvalid`.
- Simultaneous `vga_re` and `g_req` (read of 0x2A) for 3 cycles, then `vga_re` drops. Required: `g_gnt`=0 for 3 cycles, then 1 in cycle 4. `g_rvalid` in cycle 5 with data 0x05, and `vga_rvalid` in cycles 2–4.
- With STARVE_LIMIT=4, hold `vga_re`=1 and `g_req`=1. Required: `g_starved` asserts on the 5th cycle and clears the cycle after the grant.
- `clr_req` in RUN while a game read is issued. Required: `g_rvalid` is still delivered next cycle, then the full clear runs, `init_done`=0 for 2^AW cycles, and a subsequent read of 0x2A returns `INIT_VAL`.
- Assert `reset` mid-INIT at `clr_cnt`=7. Required: all outputs return to reset values, and the clear restarts from address 0.
